sa_pe_ws: RTL and testbench
===========================

Name: sa_pe_ws

Overview:
- Weight-stationary systolic processing element: signed MAC with two's-complement saturation, pipelined, with valid tracking.
- Weights are double-buffered: a shadow register is loaded through a north-to-south shift chain, then committed to the active register by a swap strobe.
- Activations and the swap strobe are forwarded east; saturated partial sums go south.
- Instantiated N×M by the array top; replaces the stand-alone combinational MAC in each array cell.

Parameters:
- MUL_DATAWIDTH, 8: signed width of activation and weight. Must be ≥ 2.
- ADD_DATAWIDTH, 16: signed width of psum in/out. Must be ≥ 2*MUL_DATAWIDTH; elaboration error otherwise.
- MAC_PIPE, 0: 0 or 1. Adds a product/psum register stage; latency = 1 + MAC_PIPE.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_wload, input, 1: shift-chain enable; shadow <= i_weight.
- i_weight, input, MUL_DATAWIDTH: weight from the north PE's shift chain.
- o_weight, output, MUL_DATAWIDTH: shadow register; drives the south PE's i_weight.
- i_wswap, input, 1: commit shadow to active weight.
- o_wswap, output, 1: i_wswap delayed 1 cycle, to east PE.
- i_act_valid, input, 1: activation valid.
- i_act, input, MUL_DATAWIDTH: signed activation from west.
- o_act_valid, output, 1: i_act_valid delayed 1 cycle.
- o_act, output, MUL_DATAWIDTH: i_act delayed 1 cycle (updates only when i_act_valid=1).
- i_psum, input, ADD_DATAWIDTH: signed partial sum from north; sampled when i_act_valid=1.
- o_psum_valid, output, 1: o_psum valid.
- o_psum, output, ADD_DATAWIDTH: saturated result to south.
- i_clr_sat, input, 1: clear sticky saturation flag.
- o_sat, output, 1: sticky flag, set by any saturating valid result.

Behaviour:
- Reset (async assert, sync-safe deassert handled at top) clears every register: shadow, active weight, o_weight, o_act, o_act_valid, o_wswap, o_psum, o_psum_valid, o_sat, pipe regs, all 0. Reset mid-operation drops in-flight results; no o_psum_valid after release until new i_act_valid.
- Weight chain: when i_wload=1, shadow <= i_weight; otherwise shadow holds. A column of N PEs loads in N cycles, last weight first.
- Swap: when i_wswap=1, active <= shadow (value before this edge). If i_wload and i_wswap are asserted in the same cycle, active gets the old shadow and shadow gets the new weight.
- Activation sampled in the same cycle as i_wswap uses the old active weight; the first activation sampled after that cycle uses the new one.
- MAC: prod = i_act * active (signed, 2*MUL_DATAWIDTH). sum = sext(prod) + sext(i_psum), computed at ADD_DATAWIDTH+1 bits, so no wrap.
- Saturation: if sum > 2^(ADD-1)-1, o_psum = 2^(ADD-1)-1. If sum < -2^(ADD-1), o_psum = -2^(ADD-1). Otherwise o_psum = sum.
- MAC_PIPE=0: product, add and saturation are combinational from i_act/i_psum, registered into o_psum; o_psum_valid = i_act_valid delayed 1.
- MAC_PIPE=1: stage 1 registers prod, i_psum and valid; stage 2 adds, saturates and registers; latency 2.
- Pipeline accepts a new operand every cycle (II=1); no backpressure. o_psum holds its last value when valid=0.
- o_sat: set on the edge where a saturated result is registered with valid=1. Cleared by i_clr_sat. If set and clear occur in the same cycle, set wins.
- i_act_valid=0: no psum computation; i_psum ignored; o_act holds.

Optional Feature:
- Macro: SA_PE_ZERO_SKIP_EN.
- Defined:
  - If i_act==0 or active==0 on a valid cycle, the multiplier path is bypassed. The product register (MAC_PIPE=1) is not updated and its stage-1 zero flag forces prod=0.
  - o_psum equals i_psum, still through the saturation/valid pipeline with identical latency.
  - Adds output port o_skip (1 bit), aligned with o_psum_valid, high when the result came from a skipped operation.
- Undefined: no o_skip port; multiplier always evaluated.
- o_psum, o_psum_valid and o_sat are bit-identical in both builds.

Test Plan:
- Weight chain/swap: wload weight 5, wswap; act 3, psum 10 with valid → o_psum=25 after 1+MAC_PIPE cycles, o_psum_valid one-cycle pulse; o_act=3 and o_act_valid one cycle after input.
- Double-buffer: active weight 2, wload 7 and wswap in the same cycle with act 4, psum 0 → result 8. Next act 4 → result 8 (old shadow 2 committed). After another swap → 28.
- Positive saturation (ADD=16): weight 127, act 127, psum 32767 → o_psum=32767, o_sat=1. Then i_clr_sat → o_sat=0. Clear and new saturation in the same cycle → o_sat stays 1.
- Negative saturation: weight 127, act -128, psum -32768 → o_psum=-32768, o_sat=1. Weight -128, act -128, psum 0 → 16384, no saturation.
- Streaming plus reset: 8 back-to-back valid acts with MAC_PIPE=1 → 8 consecutive valid results in order. Assert i_rst_n=0 mid-stream → all outputs 0 immediately; no stale valid after release.
- SA_PE_ZERO_SKIP_EN build: act 0, psum 1234 → o_psum=1234, o_skip=1. Act 1, weight 1, psum 1234 → 1235, o_skip=0.

Source files
------------

// File: rtl/sa_pe_ws.sv
// Weight-stationary systolic PE: double-buffered weight, saturating signed MAC, valid tracking.
// Optional build macro SA_PE_ZERO_SKIP_EN bypasses the multiplier on zero operands and adds o_skip.
module sa_pe_ws #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 16,
    parameter int MAC_PIPE      = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wload,
    input  logic [MUL_DATAWIDTH-1:0] i_weight,
    output logic [MUL_DATAWIDTH-1:0] o_weight,
    input  logic                     i_wswap,
    output logic                     o_wswap,
    input  logic                     i_act_valid,
    input  logic [MUL_DATAWIDTH-1:0] i_act,
    output logic                     o_act_valid,
    output logic [MUL_DATAWIDTH-1:0] o_act,
    input  logic [ADD_DATAWIDTH-1:0] i_psum,
    output logic                     o_psum_valid,
    output logic [ADD_DATAWIDTH-1:0] o_psum,
    input  logic                     i_clr_sat,
    output logic                     o_sat
`ifdef SA_PE_ZERO_SKIP_EN
    ,
    output logic                     o_skip
`endif
);

    localparam int MW = MUL_DATAWIDTH;
    localparam int AW = ADD_DATAWIDTH;
    localparam int PW = 2 * MUL_DATAWIDTH;
    localparam int SW = ADD_DATAWIDTH + 1;

    generate
        if (MUL_DATAWIDTH < 2) begin : g_bad_mul
            $error("sa_pe_ws: MUL_DATAWIDTH must be >= 2");
        end
        if (ADD_DATAWIDTH < 2 * MUL_DATAWIDTH) begin : g_bad_add
            $error("sa_pe_ws: ADD_DATAWIDTH must be >= 2*MUL_DATAWIDTH");
        end
        if (MAC_PIPE != 0 && MAC_PIPE != 1) begin : g_bad_pipe
            $error("sa_pe_ws: MAC_PIPE must be 0 or 1");
        end
    endgenerate

    logic [MW-1:0] shadow_q;
    logic [MW-1:0] active_q;
    logic [MW-1:0] act_q;
    logic          act_valid_q;
    logic          wswap_q;

    // NOTE: non-blocking assignments make a same-cycle load+swap commit the pre-edge shadow value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_q    <= '0;
            active_q    <= '0;
            act_q       <= '0;
            act_valid_q <= 1'b0;
            wswap_q     <= 1'b0;
        end else begin
            if (i_wload)     shadow_q <= i_weight;
            if (i_wswap)     active_q <= shadow_q;
            if (i_act_valid) act_q    <= i_act;
            act_valid_q <= i_act_valid;
            wswap_q     <= i_wswap;
        end
    end

    logic          skip_c;
    logic [PW-1:0] act_ext;
    logic [PW-1:0] wgt_ext;
    logic [PW-1:0] prod_c;

`ifdef SA_PE_ZERO_SKIP_EN
    assign skip_c = (i_act == '0) || (active_q == '0);
`else
    assign skip_c = 1'b0;
`endif

    assign act_ext = {{MW{i_act[MW-1]}}, i_act};
    assign wgt_ext = {{MW{active_q[MW-1]}}, active_q};
    assign prod_c  = PW'($signed(act_ext) * $signed(wgt_ext));

    // Operands presented to the add/saturate stage, either straight or one register later.
    logic [PW-1:0] add_prod;
    logic [AW-1:0] add_psum;
    logic          add_valid;
`ifdef SA_PE_ZERO_SKIP_EN
    logic          add_skip;
`endif

    generate
        if (MAC_PIPE == 0) begin : g_comb
            assign add_prod  = skip_c ? '0 : prod_c;
            assign add_psum  = i_psum;
            assign add_valid = i_act_valid;
`ifdef SA_PE_ZERO_SKIP_EN
            assign add_skip  = skip_c;
`endif
        end else begin : g_pipe
            logic [PW-1:0] prod_q;
            logic [AW-1:0] psum_q;
            logic          valid_q;
            logic          zero_q;

            // A skipped operation leaves prod_q untouched; zero_q forces the product to zero.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    prod_q  <= '0;
                    psum_q  <= '0;
                    valid_q <= 1'b0;
                    zero_q  <= 1'b0;
                end else begin
                    if (i_act_valid) begin
                        if (!skip_c) prod_q <= prod_c;
                        psum_q <= i_psum;
                        zero_q <= skip_c;
                    end
                    valid_q <= i_act_valid;
                end
            end

            assign add_prod  = zero_q ? '0 : prod_q;
            assign add_psum  = psum_q;
            assign add_valid = valid_q;
`ifdef SA_PE_ZERO_SKIP_EN
            assign add_skip  = zero_q;
`endif
        end
    endgenerate

    logic [SW-1:0] sum_c;
    logic [AW-1:0] res_c;
    logic          pos_ovf_c;
    logic          neg_ovf_c;

    assign sum_c = {{(SW-PW){add_prod[PW-1]}}, add_prod} + {add_psum[AW-1], add_psum};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pos_ovf_c = ~sum_c[SW-1] &  sum_c[SW-2];
        neg_ovf_c =  sum_c[SW-1] & ~sum_c[SW-2];
        res_c     = sum_c[AW-1:0];
        if (pos_ovf_c)      res_c = {1'b0, {(AW-1){1'b1}}};
        else if (neg_ovf_c) res_c = {1'b1, {(AW-1){1'b0}}};
    end

    logic [AW-1:0] psum_q;
    logic          psum_valid_q;
    logic          sat_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            if (add_valid) psum_q <= res_c;
            psum_valid_q <= add_valid;
            if (add_valid && (pos_ovf_c || neg_ovf_c)) sat_q <= 1'b1;
            else if (i_clr_sat)                        sat_q <= 1'b0;
        end
    end

`ifdef SA_PE_ZERO_SKIP_EN
    logic skip_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) skip_q <= 1'b0;
        else          skip_q <= add_valid & add_skip;
    end

    assign o_skip = skip_q;
`endif

    assign o_weight     = shadow_q;
    assign o_wswap      = wswap_q;
    assign o_act        = act_q;
    assign o_act_valid  = act_valid_q;
    assign o_psum       = psum_q;
    assign o_psum_valid = psum_valid_q;
    assign o_sat        = sat_q;

endmodule

// File: tb/tb_sa_pe_ws.sv
// Scoreboard bench for sa_pe_ws: MAC_PIPE=0 and MAC_PIPE=1 instances share stimulus,
// expected results come from an arithmetic model and are checked by a separate monitor.
module tb_sa_pe_ws;

    localparam int MW = 8;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_wload     = 1'b0;
    logic [MW-1:0] i_weight    = '0;
    logic          i_wswap     = 1'b0;
    logic          i_act_valid = 1'b0;
    logic [MW-1:0] i_act       = '0;
    logic [AW-1:0] i_psum      = '0;
    logic          i_clr_sat   = 1'b0;

    logic [MW-1:0] o_weight0, o_weight1, o_act0, o_act1;
    logic          o_wswap0, o_wswap1, o_act_valid0, o_act_valid1;
    logic          o_psum_valid0, o_psum_valid1, o_sat0, o_sat1;
    logic [AW-1:0] o_psum0, o_psum1;
    logic          o_skip0, o_skip1;

    sa_pe_ws #(.MUL_DATAWIDTH(MW), .ADD_DATAWIDTH(AW), .MAC_PIPE(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wload(i_wload), .i_weight(i_weight), .o_weight(o_weight0),
        .i_wswap(i_wswap), .o_wswap(o_wswap0),
        .i_act_valid(i_act_valid), .i_act(i_act),
        .o_act_valid(o_act_valid0), .o_act(o_act0),
        .i_psum(i_psum), .o_psum_valid(o_psum_valid0), .o_psum(o_psum0),
        .i_clr_sat(i_clr_sat), .o_sat(o_sat0)
`ifdef SA_PE_ZERO_SKIP_EN
        , .o_skip(o_skip0)
`endif
    );

    sa_pe_ws #(.MUL_DATAWIDTH(MW), .ADD_DATAWIDTH(AW), .MAC_PIPE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wload(i_wload), .i_weight(i_weight), .o_weight(o_weight1),
        .i_wswap(i_wswap), .o_wswap(o_wswap1),
        .i_act_valid(i_act_valid), .i_act(i_act),
        .o_act_valid(o_act_valid1), .o_act(o_act1),
        .i_psum(i_psum), .o_psum_valid(o_psum_valid1), .o_psum(o_psum1),
        .i_clr_sat(i_clr_sat), .o_sat(o_sat1)
`ifdef SA_PE_ZERO_SKIP_EN
        , .o_skip(o_skip1)
`endif
    );

`ifndef SA_PE_ZERO_SKIP_EN
    assign o_skip0 = 1'b0;
    assign o_skip1 = 1'b0;
`endif

    typedef struct {
        int psum;
        bit sat;
        bit skip;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    // Reference state: what the PE should hold after the most recent clock edge.
    int shadow_m, active_m, exp_weight, exp_act;
    bit exp_act_v, exp_wswap, clr_edge;
    bit sat_m[2];
    int last_ps[2];

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d expected %0d", name, $time, act, expv);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference model: samples inputs at each rising edge and pushes expected results.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                shadow_m = 0; active_m = 0; exp_weight = 0; exp_act = 0;
                exp_act_v = 0; exp_wswap = 0; clr_edge = 0;
                q0.delete(); q1.delete();
            end else begin
                if (i_act_valid) begin
                    int a, s, raw;
                    exp_t e;
                    a      = $signed(i_act);
                    s      = $signed(i_psum);
                    raw    = a * active_m + s;
                    e.psum = clamp(raw);
                    e.sat  = (raw != e.psum);
                    e.skip = (a == 0) || (active_m == 0);
                    q0.push_back(e);
                    q1.push_back(e);
                    exp_act = a;
                end
                exp_act_v = i_act_valid;
                exp_wswap = i_wswap;
                clr_edge  = i_clr_sat;
                if (i_wswap) active_m = shadow_m;
                if (i_wload) shadow_m = $signed(i_weight);
                exp_weight = shadow_m;
            end
        end
    end

    task automatic mon(input int d, input logic pv, input logic [AW-1:0] ps,
                       input logic st, input logic sk);
        exp_t e;
        bit   got;
        got = 0;
        if (pv) begin
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
            if (!got) begin
                check($sformatf("unexpected_valid%0d", d), 1, 0);
                if (clr_edge) sat_m[d] = 0;
            end else begin
                check($sformatf("psum%0d", d), $signed(ps), e.psum);
`ifdef SA_PE_ZERO_SKIP_EN
                check($sformatf("skip%0d", d), int'(sk), int'(e.skip));
`endif
                if (e.sat)         sat_m[d] = 1;
                else if (clr_edge) sat_m[d] = 0;
                last_ps[d] = e.psum;
            end
        end else begin
            if (clr_edge) sat_m[d] = 0;
            check($sformatf("psum_hold%0d", d), $signed(ps), last_ps[d]);
`ifdef SA_PE_ZERO_SKIP_EN
            check($sformatf("skip_idle%0d", d), int'(sk), 0);
`endif
        end
        check($sformatf("sat%0d", d), int'(st), int'(sat_m[d]));
    endtask

    // Monitor: compares every output on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sat_m[0] = 0; sat_m[1] = 0; last_ps[0] = 0; last_ps[1] = 0;
            end else begin
                mon(0, o_psum_valid0, o_psum0, o_sat0, o_skip0);
                mon(1, o_psum_valid1, o_psum1, o_sat1, o_skip1);
                check("weight0", $signed(o_weight0), exp_weight);
                check("weight1", $signed(o_weight1), exp_weight);
                check("act0", $signed(o_act0), exp_act);
                check("act1", $signed(o_act1), exp_act);
                check("act_valid0", int'(o_act_valid0), int'(exp_act_v));
                check("act_valid1", int'(o_act_valid1), int'(exp_act_v));
                check("wswap0", int'(o_wswap0), int'(exp_wswap));
                check("wswap1", int'(o_wswap1), int'(exp_wswap));
            end
        end
    end

    task automatic drive(input bit wl, input int w, input bit sw, input bit av,
                         input int a, input int ps, input bit clr);
        @(negedge clk);
        i_wload     = wl;
        i_weight    = MW'(w);
        i_wswap     = sw;
        i_act_valid = av;
        i_act       = MW'(a);
        i_psum      = AW'(ps);
        i_clr_sat   = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psum0"}, int'(o_psum0), 0);
        check({tag, "_psum1"}, int'(o_psum1), 0);
        check({tag, "_pv"}, int'(o_psum_valid0) + int'(o_psum_valid1), 0);
        check({tag, "_sat"}, int'(o_sat0) + int'(o_sat1), 0);
        check({tag, "_weight"}, int'(o_weight0) + int'(o_weight1), 0);
        check({tag, "_act"}, int'(o_act0) + int'(o_act1), 0);
        check({tag, "_av"}, int'(o_act_valid0) + int'(o_act_valid1), 0);
        check({tag, "_wswap"}, int'(o_wswap0) + int'(o_wswap1), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load 5, commit, then 3*5+10.
        drive(1, 5, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 10, 0);
        idle(3);
        check("plan_25_dut0", $signed(o_psum0), 25);
        check("plan_25_dut1", $signed(o_psum1), 25);

        // Double buffer: active 2, then load 7 with swap and activation in one cycle.
        drive(1, 2, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(1, 7, 1, 1, 4, 0, 0);
        drive(0, 0, 0, 1, 4, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 4, 0, 0);
        idle(3);
        check("dbuf_28_dut0", $signed(o_psum0), 28);
        check("dbuf_28_dut1", $signed(o_psum1), 28);

        // Positive saturation, clear, then clear racing a new saturation.
        drive(1, 127, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 127, 32767, 0);
        idle(2);
        check("pos_sat_dut0", $signed(o_psum0), 32767);
        check("pos_sat_flag", int'(o_sat0) + int'(o_sat1), 2);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("sat_cleared", int'(o_sat0) + int'(o_sat1), 0);
        drive(0, 0, 0, 1, 127, 32767, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        check("sat_set_wins_dut1", int'(o_sat1), 1);
        drive(0, 0, 0, 0, 0, 0, 1);

        // Negative saturation, then -128*-128 which fits.
        drive(0, 0, 0, 1, -128, -32768, 0);
        idle(2);
        check("neg_sat_dut1", $signed(o_psum1), -32768);
        drive(1, -128, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, -128, 0, 0);
        idle(2);
        check("neg_fit_dut0", $signed(o_psum0), 16384);
        check("neg_fit_dut1", $signed(o_psum1), 16384);

        // Zero operands and unit product.
        drive(0, 0, 0, 1, 0, 1234, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 1234, 0);
        idle(2);
        check("unit_dut1", $signed(o_psum1), 1235);

        // Randomized traffic with extreme partial sums mixed in.
        for (int i = 0; i < 60; i++) begin
            int ps;
            ps = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 32767 : -32768)
                                           : int'($signed(16'($urandom)));
            drive($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 7) == 0 ? 0 : int'($urandom), ps,
                  $urandom_range(0, 9) == 0);
        end
        idle(3);

        // Back-to-back stream, then reset while results are in flight.
        drive(1, 3, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, i - 4, 100 * i, 0);
        idle(3);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 20 + i, -5, 0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
